// File: rtl/window_stream_sequencer.sv
// Per-layer sequencer for the conv sliding-window line buffer.
// Latches a layer descriptor, clears the window and streams dim*dim pixels through a 2-entry FIFO.
module window_stream_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            cfg_input_dim,
    input  logic                  cfg_stride,
    input  logic [1:0]            cfg_window_dim,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  win_reset,
    output logic                  win_stride,
    output logic [1:0]            win_window_dim,
    output logic [7:0]            win_input_dim,
    output logic [DATA_WIDTH-1:0] win_new_data,
    output logic                  win_new_data_valid,
    input  logic                  win_in_rd_en,
    input  logic                  win_window_valid,
    output logic [CNT_WIDTH-1:0]  win_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  win_reset_q, win_reset_d;
    logic                  stride_q, stride_d;
    logic [1:0]            wdim_q, wdim_d;
    logic [7:0]            dim_q, dim_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
    logic [CNT_WIDTH-1:0]  win_count_q, win_count_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    logic                  dim_legal;
    logic [CNT_WIDTH-1:0]  n_pix;
    logic                  fifo_valid;
    logic                  push;
    logic                  pop;
    logic [1:0]            slots_used;
    logic                  rd_en;

    always_comb begin
        case (cfg_input_dim)
            8'd224, 8'd112, 8'd56,
            8'd28, 8'd14, 8'd7: dim_legal = 1'b1;
            default:            dim_legal = 1'b0;
        endcase
    end

    assign n_pix      = CNT_WIDTH'(dim_q) * CNT_WIDTH'(dim_q);
    assign fifo_valid = (occ_q != 2'd0);
    assign pop        = fifo_valid && win_in_rd_en;
    assign push       = inflight_q;

    // A pop in this cycle frees a slot, which keeps the stream at 1 pixel/cycle.
    assign slots_used = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign rd_en      = (state_q == S_FETCH) && (rd_cnt_q < n_pix)
                        && (slots_used < 2'd2);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        win_reset_d = 1'b0;
        stride_d    = stride_q;
        wdim_d      = wdim_q;
        dim_d       = dim_q;
        base_d      = base_q;
        inflight_d  = rd_en;
        rd_cnt_d    = rd_cnt_q + CNT_WIDTH'(rd_en);
        pop_cnt_d   = pop_cnt_q + CNT_WIDTH'(pop);
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        win_count_d = win_count_q;

        if (push) begin
            fifo_d[wr_ptr_q] = mem_rd_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (busy_q && win_window_valid && (win_count_q != '1)) begin
            win_count_d = win_count_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && dim_legal) begin
                    state_d     = S_CLEAR;
                    busy_d      = 1'b1;
                    win_reset_d = 1'b1;
                    stride_d    = cfg_stride;
                    wdim_d      = cfg_window_dim;
                    dim_d       = cfg_input_dim;
                    base_d      = cfg_base_addr;
                    rd_cnt_d    = '0;
                    pop_cnt_d   = '0;
                    win_count_d = '0;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (pop_cnt_d == n_pix) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            win_reset_q <= 1'b0;
            stride_q    <= 1'b0;
            wdim_q      <= '0;
            dim_q       <= '0;
            base_q      <= '0;
            rd_cnt_q    <= '0;
            pop_cnt_q   <= '0;
            win_count_q <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            win_reset_q <= win_reset_d;
            stride_q    <= stride_d;
            wdim_q      <= wdim_d;
            dim_q       <= dim_d;
            base_q      <= base_d;
            rd_cnt_q    <= rd_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            win_count_q <= win_count_d;
            inflight_q  <= inflight_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign cfg_err            = cfg_err_q;
    assign mem_rd_en          = rd_en;
    assign mem_rd_addr        = base_q + ADDR_WIDTH'(rd_cnt_q);
    assign win_reset          = win_reset_q;
    assign win_stride         = stride_q;
    assign win_window_dim     = wdim_q;
    assign win_input_dim      = dim_q;
    assign win_new_data       = fifo_q[rd_ptr_q];
    assign win_new_data_valid = fifo_valid;
    assign win_count          = win_count_q;

endmodule
